mem_store_seq: RTL and testbench



---
 rtl/mem_store_seq_if.sv | 35 +++
 rtl/mem_store_seq.sv | 170 +++++++++++++++++
 tb/tb_mem_store_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_seq_if.sv
// AXI4 write-channel bundle (AW, W, B) between the store sequencer (master)
// and the memory-side slave.
interface mem_store_seq_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/mem_store_seq.sv
// Store sequencer: turns a memory-stage store request into one (or, with
// STORE_SPLIT_EN defined, two) single-beat AXI writes and reports completion.
module mem_store_seq #(
  parameter logic [3:0] AW_ID    = 4'd1,
  parameter logic [1:0] ERR_MASK = 2'b10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_two,
  input  logic [31:0]           addr1,
  input  logic [31:0]           data1,
  input  logic [1:0]            size1,
  input  logic [31:0]           addr2,
  input  logic [31:0]           data2,
  input  logic [1:0]            size2,
  output logic                  done,
  output logic                  err,
  mem_store_seq_if.master       axi
);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr1_q, data1_q;
  logic [1:0]  size1_q;
  logic        aw_done, w_done, err_acc;
  logic        done_q, err_q;
  logic [31:0] cur_addr, cur_data;
  logic [1:0]  cur_size;
  logic        accept, aw_hs, w_hs, b_hs, last_beat, bresp_err;

  function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  assign accept    = (state == IDLE) && req_valid;
  assign aw_hs     = (state == SEND) && !aw_done && axi.awready;
  assign w_hs      = (state == SEND) && !w_done && axi.wready;
  assign b_hs      = (state == RESP) && axi.bvalid;
  assign bresp_err = |(axi.bresp & ERR_MASK);

`ifdef STORE_SPLIT_EN
  logic [31:0] addr2_q, data2_q;
  logic [1:0]  size2_q;
  logic        two_q, beat;

  always_ff @(posedge clk) begin
    if (accept) begin
      two_q   <= req_two;
      addr2_q <= addr2;
      data2_q <= data2;
      size2_q <= size2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    beat <= 1'b0;
    else if (accept)              beat <= 1'b0;
    else if (b_hs && !last_beat)  beat <= 1'b1;
  end

  assign last_beat = !two_q || beat;
  assign cur_addr  = beat ? addr2_q : addr1_q;
  assign cur_data  = beat ? data2_q : data1_q;
  assign cur_size  = beat ? size2_q : size1_q;
`else
  // Second-beat inputs have no function in the single-beat build.
  logic unused_split;
  assign unused_split = ^{req_two, addr2, data2, size2};

  assign last_beat = 1'b1;
  assign cur_addr  = addr1_q;
  assign cur_data  = data1_q;
  assign cur_size  = size1_q;
`endif

  // NOTE: payload registers carry no reset; they are loaded on acceptance
  // before anything observes them, and every output is gated during reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr1_q <= addr1;
      data1_q <= data1;
      size1_q <= size1;
    end
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_acc <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_acc <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        err_acc <= err_acc | bresp_err;
        if (last_beat) begin
          done_q <= 1'b1;
          err_q  <= err_acc | bresp_err;
        end else begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = SEND;
      SEND:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = RESP;
      RESP:    if (axi.bvalid) state_nxt = last_beat ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    req_ready   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    axi.awid    = '0;
    axi.awaddr  = '0;
    axi.awsize  = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    if (!reset) begin
      req_ready   = (state == IDLE);
      done        = done_q;
      err         = err_q;
      axi.awid    = AW_ID;
      axi.awaddr  = cur_addr;
      axi.awsize  = {1'b0, cur_size};
      axi.awvalid = (state == SEND) && !aw_done;
      axi.wdata   = cur_data;
      axi.wstrb   = strb_of(cur_size, cur_addr[1:0]);
      axi.wlast   = 1'b1;
      axi.wvalid  = (state == SEND) && !w_done;
      axi.bready  = (state == RESP);
    end
  end

endmodule

// File: tb/tb_mem_store_seq.sv
// Directed bench for mem_store_seq; split-store steps run only when
// STORE_SPLIT_EN is defined for the build.
module tb_mem_store_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_two;
  logic [31:0] addr1, data1, addr2, data2;
  logic [1:0]  size1, size2;
  logic        done, err;
  int          n_pass = 0;
  int          n_total = 0;

  mem_store_seq_if axi();

  mem_store_seq #(.AW_ID(4'd1), .ERR_MASK(2'b10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_two(req_two),
    .addr1(addr1), .data1(data1), .size1(size1),
    .addr2(addr2), .data2(data2), .size2(size2),
    .done(done), .err(err), .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control vector order: {req_ready, awvalid, wvalid, bready, done, err}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, req_ready, axi.awvalid, axi.wvalid, axi.bready, done, err}, {26'd0, exp});
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz, input logic [3:0] strb);
    check({tag, "_awaddr"}, axi.awaddr, a);
    check({tag, "_wdata"}, axi.wdata, d);
    check({tag, "_attr"}, {20'd0, axi.awid, axi.awsize, axi.wstrb, axi.wlast},
          {20'd0, 4'd1, sz, strb, 1'b1});
  endtask

  // One single-beat store against an always-ready slave; starts and ends in IDLE.
  task automatic single_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] s, input logic two, input logic [1:0] resp,
                             input logic [3:0] strb, input logic exp_err);
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = resp;
    req_valid = 1'b1; req_two = two;
    addr1 = a; data1 = d; size1 = s;
    addr2 = 32'h5555_0000; data2 = ~d; size2 = 2'b10;
    tick();
    req_valid = 1'b0; req_two = 1'b0; addr1 = ~a; data1 = 32'h0; size1 = ~s;
    chk_ctl({tag, "_send"}, 6'b011000);
    chk_beat(tag, a, d, {1'b0, s}, strb);
    tick();
    chk_ctl({tag, "_resp"}, 6'b000100);
    tick();
    chk_ctl({tag, "_done"}, {5'b10001, exp_err});
    tick();
    chk_ctl({tag, "_idle"}, 6'b100000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_two = 1'b0;
    addr1 = '0; data1 = '0; size1 = '0; addr2 = '0; data2 = '0; size2 = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b1; axi.bresp = 2'b10;

    // Reset: everything low, bvalid ignored.
    tick();
    chk_ctl("rst_ctl", 6'b000000);
    check("rst_awaddr", axi.awaddr, 32'h0);
    check("rst_attr", {20'd0, axi.awid, axi.awsize, axi.wstrb, axi.wlast}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk_ctl("rst_release", 6'b100000);

    // Single beats, back-to-back, covering every strobe rule and the bresp mask.
    single_beat("word",  32'h0000_1000, 32'hDEAD_BEEF, 2'b10, 1'b0, 2'b00, 4'b1111, 1'b0);
    single_beat("byte3", 32'h0000_1003, 32'hAB00_0000, 2'b00, 1'b0, 2'b01, 4'b1000, 1'b0);
    single_beat("half2", 32'h0000_1002, 32'hBEEF_0000, 2'b01, 1'b0, 2'b00, 4'b1100, 1'b0);
    single_beat("byte1", 32'h0000_1001, 32'h0000_CD00, 2'b00, 1'b0, 2'b00, 4'b0010, 1'b0);
    single_beat("size3", 32'h0000_1004, 32'h0102_0304, 2'b11, 1'b0, 2'b00, 4'b1111, 1'b0);
    single_beat("err10", 32'h0000_3000, 32'h1111_2222, 2'b10, 1'b0, 2'b10, 4'b1111, 1'b1);
    single_beat("err11", 32'h0000_3004, 32'h3333_4444, 2'b10, 1'b0, 2'b11, 4'b1111, 1'b1);
    single_beat("clean", 32'h0000_3008, 32'h5555_6666, 2'b10, 1'b0, 2'b00, 4'b1111, 1'b0);
`ifndef STORE_SPLIT_EN
    single_beat("two_ign", 32'h0000_2000, 32'h1234_5678, 2'b10, 1'b1, 2'b00, 4'b1111, 1'b0);
`endif

    // awready held low for four cycles while wready is high.
    axi.awready = 1'b0; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    req_valid = 1'b1; addr1 = 32'h0000_4000; data1 = 32'h1122_3344; size1 = 2'b10;
    tick();
    req_valid = 1'b0;
    chk_ctl("skew_c1", 6'b011000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ctl("skew_hold", 6'b010000);
      check("skew_addr", axi.awaddr, 32'h0000_4000);
    end
    axi.awready = 1'b1;
    tick();
    chk_ctl("skew_resp", 6'b000100);
    tick();
    chk_ctl("skew_bwait", 6'b000100);
    axi.bvalid = 1'b1;
    tick();
    chk_ctl("skew_done", 6'b100010);
    axi.bvalid = 1'b0;

    // wready late instead.
    axi.awready = 1'b1; axi.wready = 1'b0;
    req_valid = 1'b1; addr1 = 32'h0000_4010;
    tick();
    req_valid = 1'b0;
    chk_ctl("wskew_c1", 6'b011000);
    tick();
    chk_ctl("wskew_hold", 6'b001000);
    axi.wready = 1'b1; axi.bvalid = 1'b1;
    tick();
    chk_ctl("wskew_resp", 6'b000100);
    tick();
    chk_ctl("wskew_done", 6'b100010);
    tick();

`ifdef STORE_SPLIT_EN
    // Two beats, clean responses: done five cycles after acceptance.
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = 2'b00;
    req_valid = 1'b1; req_two = 1'b1;
    addr1 = 32'h0000_2000; data1 = 32'h0000_1234; size1 = 2'b01;
    addr2 = 32'h0000_2001; data2 = 32'h0000_AB00; size2 = 2'b00;
    tick();
    req_valid = 1'b0; req_two = 1'b0; addr2 = 32'hFFFF_FFFF;
    chk_ctl("split_s1", 6'b011000);
    chk_beat("split_b1", 32'h0000_2000, 32'h0000_1234, 3'b001, 4'b0011);
    tick();
    chk_ctl("split_r1", 6'b000100);
    tick();
    chk_ctl("split_s2", 6'b011000);
    chk_beat("split_b2", 32'h0000_2001, 32'h0000_AB00, 3'b000, 4'b0010);
    tick();
    chk_ctl("split_r2", 6'b000100);
    tick();
    chk_ctl("split_done", 6'b100010);
    tick();

    // Error on the first of two beats still issues the second and reports err.
    req_valid = 1'b1; req_two = 1'b1;
    addr1 = 32'h0000_2100; data1 = 32'hCAFE_F00D; size1 = 2'b10;
    addr2 = 32'h0000_2104; data2 = 32'h0BAD_F00D; size2 = 2'b10;
    tick();
    req_valid = 1'b0; req_two = 1'b0;
    chk_ctl("serr_s1", 6'b011000);
    axi.bresp = 2'b10;
    tick();
    chk_ctl("serr_r1", 6'b000100);
    tick();
    axi.bresp = 2'b00;
    chk_ctl("serr_s2", 6'b011000);
    chk_beat("serr_b2", 32'h0000_2104, 32'h0BAD_F00D, 3'b010, 4'b1111);
    tick();
    chk_ctl("serr_r2", 6'b000100);
    tick();
    chk_ctl("serr_done", 6'b100011);
    tick();
`endif

    // Reset while waiting in RESP aborts without a done pulse.
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    req_valid = 1'b1; addr1 = 32'h0000_5000; data1 = 32'h7777_8888; size1 = 2'b10;
    tick();
    req_valid = 1'b0;
    chk_ctl("abort_send", 6'b011000);
    tick();
    chk_ctl("abort_resp", 6'b000100);
    reset = 1'b1; axi.bvalid = 1'b1; axi.bresp = 2'b10;
    #1;
    chk_ctl("abort_rst_ctl", 6'b000000);
    check("abort_rst_addr", axi.awaddr, 32'h0);
    tick();
    chk_ctl("abort_rst_hold", 6'b000000);
    reset = 1'b0;
    #1;
    chk_ctl("abort_release", 6'b100000);
    tick();
    chk_ctl("abort_no_done", 6'b100000);
    axi.bvalid = 1'b0;
    single_beat("post_rst", 32'h0000_6000, 32'h0A0B_0C0D, 2'b10, 1'b0, 2'b00, 4'b1111, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
